// File: rtl/axis_traffic_gen.sv
// axis_traffic_gen: AXI-Stream packet generator for a mesh endpoint.
// Sends num_pkts packets of pkt_len beats. The destination is fixed,
// round-robin or LFSR-chosen. An optional receive checker validates traffic
// addressed to this endpoint; it is compiled in when AXIS_TGEN_CHECKER_EN is
// defined.
// Handshake rule (both streams): a beat transfers on a rising clk_usr edge where
// tvalid and tready are both high. While tvalid is high and tready is low, the
// source holds tdata, tlast and tdest unchanged.
module axis_traffic_gen #(
    parameter int TDATA_WIDTH = 32,
    parameter int TDEST_WIDTH = 4,
    parameter int NUM_DESTS   = 4,
    parameter int SRC_ID      = 0,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                   clk_usr,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic [1:0]             mode,
    input  logic [TDEST_WIDTH-1:0] fixed_dest,
    input  logic [7:0]             pkt_len,
    input  logic [CNT_WIDTH-1:0]   num_pkts,
    output logic                   tx_tvalid,
    input  logic                   tx_tready,
    output logic [TDATA_WIDTH-1:0] tx_tdata,
    output logic                   tx_tlast,
    output logic [TDEST_WIDTH-1:0] tx_tdest,
    input  logic                   rx_tvalid,
    output logic                   rx_tready,
    input  logic [TDATA_WIDTH-1:0] rx_tdata,
    input  logic                   rx_tlast,
    input  logic [TDEST_WIDTH-1:0] rx_tdest,
    output logic                   busy,
    output logic                   done,
    output logic [CNT_WIDTH-1:0]   tx_pkt_count,
    output logic [CNT_WIDTH-1:0]   rx_pkt_count,
    output logic [CNT_WIDTH-1:0]   rx_err_count,
    output logic [1:0]             state_dbg
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [15:0]            LFSR_SEED = 16'hACE1;
    localparam logic [TDEST_WIDTH-1:0] DEST_MASK = TDEST_WIDTH'(NUM_DESTS - 1);
    localparam logic [TDEST_WIDTH-1:0] SRC_DEST  = TDEST_WIDTH'(SRC_ID);

    state_t                 state_q;
    logic [1:0]             mode_q;
    logic [TDEST_WIDTH-1:0] fixed_dest_q;
    logic [7:0]             last_idx_q;    // latched pkt_len-1 (pkt_len 0 acts as 1)
    logic [CNT_WIDTH-1:0]   num_pkts_q;
    logic [CNT_WIDTH-1:0]   pkt_seq_q;     // index of the packet currently on the wire
    logic [7:0]             beat_idx_q;
    logic [15:0]            lfsr_q;
    logic [TDEST_WIDTH-1:0] rr_q;
    logic                   abort_pend_q;

    // Beat payload: source id in the top byte, sequence and beat index below.
    function automatic logic [TDATA_WIDTH-1:0] beat_word(input logic [7:0] seq,
                                                         input logic [7:0] idx);
        logic [TDATA_WIDTH-1:0] w;
        w = '0;
        w[TDATA_WIDTH-1 -: 8] = 8'(SRC_ID);
        w[15:8] = seq;
        w[7:0]  = idx;
        return w;
    endfunction

    // x^16+x^14+x^13+x^11+1, shifting towards the MSB.
    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    function automatic logic [TDEST_WIDTH-1:0] pick_dest(input logic [1:0]             m,
                                                         input logic [TDEST_WIDTH-1:0] fd,
                                                         input logic [TDEST_WIDTH-1:0] rr,
                                                         input logic [15:0]            lf);
        logic [TDEST_WIDTH-1:0] d;
        case (m)
            2'd1:    d = rr;
            2'd2:    d = TDEST_WIDTH'(lf) & DEST_MASK;
            default: d = fd;
        endcase
        return d;
    endfunction

    logic                   start_take;
    logic                   tx_fire;
    logic [1:0]             mode_in;
    logic [15:0]            lfsr_adv;
    logic [TDEST_WIDTH-1:0] rr_adv;
    logic [CNT_WIDTH-1:0]   seq_adv;
    logic                   final_pkt;
    logic [7:0]             beat_adv;

    assign start_take = start && (state_q != ST_SEND);
    assign tx_fire    = tx_tvalid && tx_tready;
    assign mode_in    = (mode == 2'd3) ? 2'd0 : mode;
    assign lfsr_adv   = lfsr_next(lfsr_q);
    assign rr_adv     = (rr_q == DEST_MASK) ? '0 : rr_q + 1'b1;
    assign seq_adv    = pkt_seq_q + 1'b1;
    // Abort seen anywhere in this packet, including its tlast cycle, ends the run.
    assign final_pkt  = abort_pend_q || abort || (pkt_seq_q == num_pkts_q - 1'b1);
    assign beat_adv   = beat_idx_q + 8'd1;
    assign state_dbg  = state_q;

    // Run control FSM; also owns the registered tx stream and tx packet counter.
    always_ff @(posedge clk_usr) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            mode_q       <= 2'd0;
            fixed_dest_q <= '0;
            last_idx_q   <= 8'd0;
            num_pkts_q   <= '0;
            pkt_seq_q    <= '0;
            beat_idx_q   <= 8'd0;
            lfsr_q       <= LFSR_SEED;
            rr_q         <= '0;
            abort_pend_q <= 1'b0;
            tx_tvalid    <= 1'b0;
            tx_tdata     <= '0;
            tx_tlast     <= 1'b0;
            tx_tdest     <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            tx_pkt_count <= '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        mode_q       <= mode_in;
                        fixed_dest_q <= fixed_dest;
                        last_idx_q   <= (pkt_len == 8'd0) ? 8'd0 : pkt_len - 8'd1;
                        num_pkts_q   <= num_pkts;
                        pkt_seq_q    <= '0;
                        beat_idx_q   <= 8'd0;
                        lfsr_q       <= LFSR_SEED;
                        rr_q         <= '0;
                        abort_pend_q <= 1'b0;
                        tx_pkt_count <= '0;
                        if (num_pkts == '0) begin
                            state_q   <= ST_DONE;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            tx_tvalid <= 1'b0;
                        end else begin
                            state_q   <= ST_SEND;
                            busy      <= 1'b1;
                            done      <= 1'b0;
                            tx_tvalid <= 1'b1;
                            tx_tdata  <= beat_word(8'd0, 8'd0);
                            tx_tlast  <= (pkt_len <= 8'd1);
                            tx_tdest  <= pick_dest(mode_in, fixed_dest, '0, LFSR_SEED);
                        end
                    end
                end
                ST_SEND: begin
                    if (abort) begin
                        abort_pend_q <= 1'b1;
                    end
                    if (tx_fire) begin
                        if (tx_tlast) begin
                            if (tx_pkt_count != '1) begin
                                tx_pkt_count <= tx_pkt_count + 1'b1;
                            end
                            lfsr_q       <= lfsr_adv;
                            rr_q         <= rr_adv;
                            pkt_seq_q    <= seq_adv;
                            beat_idx_q   <= 8'd0;
                            abort_pend_q <= 1'b0;
                            if (final_pkt) begin
                                state_q   <= ST_DONE;
                                busy      <= 1'b0;
                                done      <= 1'b1;
                                tx_tvalid <= 1'b0;
                                tx_tdata  <= '0;
                                tx_tlast  <= 1'b0;
                                tx_tdest  <= '0;
                            end else begin
                                tx_tdata <= beat_word(8'(seq_adv), 8'd0);
                                tx_tlast <= (last_idx_q == 8'd0);
                                tx_tdest <= pick_dest(mode_q, fixed_dest_q, rr_adv, lfsr_adv);
                            end
                        end else begin
                            beat_idx_q <= beat_adv;
                            tx_tdata   <= beat_word(8'(pkt_seq_q), beat_adv);
                            tx_tlast   <= (beat_adv == last_idx_q);
                        end
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    tx_tvalid <= 1'b0;
                end
            endcase
        end
    end

    // Receive side is always ready once out of reset.
    always_ff @(posedge clk_usr) begin
        if (!rst_n) begin
            rx_tready <= 1'b0;
        end else begin
            rx_tready <= 1'b1;
        end
    end

`ifdef AXIS_TGEN_CHECKER_EN
    logic [7:0] rx_idx_q;
    logic       rx_fire;
    logic       rx_bad;
    logic       unused_rx_hi;

    assign rx_fire      = rx_tvalid && rx_tready;
    assign rx_bad       = (rx_tdest != SRC_DEST) ||
                          (rx_tdata[7:0] != rx_idx_q) ||
                          (rx_tlast != (rx_idx_q == last_idx_q));
    assign unused_rx_hi = ^rx_tdata[TDATA_WIDTH-1:8];

    // Receive checker: beat index tracking plus saturating packet/error counts.
    // A start clears the counts and takes priority over a beat in that cycle.
    always_ff @(posedge clk_usr) begin
        if (!rst_n) begin
            rx_idx_q     <= 8'd0;
            rx_pkt_count <= '0;
            rx_err_count <= '0;
        end else begin
            if (rx_fire) begin
                rx_idx_q <= rx_tlast ? 8'd0 : rx_idx_q + 8'd1;
            end
            if (start_take) begin
                rx_pkt_count <= '0;
                rx_err_count <= '0;
            end else if (rx_fire) begin
                if (rx_tlast && (rx_pkt_count != '1)) begin
                    rx_pkt_count <= rx_pkt_count + 1'b1;
                end
                if (rx_bad && (rx_err_count != '1)) begin
                    rx_err_count <= rx_err_count + 1'b1;
                end
            end
        end
    end
`else
    logic unused_rx;

    assign unused_rx    = ^{rx_tvalid, rx_tdata, rx_tlast, rx_tdest, start_take};
    assign rx_pkt_count = '0;
    assign rx_err_count = '0;
`endif

endmodule

// File: tb/tb_axis_traffic_gen.sv
// Bench for axis_traffic_gen: a queue-based scoreboard fed by a reference
// model of the beat stream, plus directed run-control and receive-checker cases.
module tb_axis_traffic_gen;

    localparam int TDW  = 32;
    localparam int TDST = 4;
    localparam int ND   = 4;
    localparam int CW   = 16;
    localparam int W    = TDST + 1 + TDW;
`ifdef AXIS_TGEN_CHECKER_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- DUT A (SRC_ID=2, tx stream) ----------------
    logic            start, abort, tx_tready, tx_tvalid, tx_tlast, busy, done, rx_tready;
    logic [1:0]      mode, state_dbg;
    logic [TDST-1:0] fixed_dest, tx_tdest;
    logic [7:0]      pkt_len;
    logic [CW-1:0]   num_pkts, tx_pkt_count, rx_pkt_count, rx_err_count;
    logic [TDW-1:0]  tx_tdata;

    axis_traffic_gen #(.TDATA_WIDTH(TDW), .TDEST_WIDTH(TDST), .NUM_DESTS(ND),
                       .SRC_ID(2), .CNT_WIDTH(CW)) dut (
        .clk_usr(clk), .rst_n(rst_n), .start(start), .abort(abort), .mode(mode),
        .fixed_dest(fixed_dest), .pkt_len(pkt_len), .num_pkts(num_pkts),
        .tx_tvalid(tx_tvalid), .tx_tready(tx_tready), .tx_tdata(tx_tdata),
        .tx_tlast(tx_tlast), .tx_tdest(tx_tdest),
        .rx_tvalid(1'b0), .rx_tready(rx_tready), .rx_tdata('0), .rx_tlast(1'b0),
        .rx_tdest('0), .busy(busy), .done(done), .tx_pkt_count(tx_pkt_count),
        .rx_pkt_count(rx_pkt_count), .rx_err_count(rx_err_count), .state_dbg(state_dbg)
    );

    // ---------------- DUT B (SRC_ID=3, rx checker) ----------------
    logic            b_start, b_tx_tvalid, b_tx_tlast, b_busy, b_done, b_rx_tready;
    logic            b_rx_tvalid, b_rx_tlast;
    logic [1:0]      b_state_dbg;
    logic [TDST-1:0] b_tx_tdest, b_rx_tdest;
    logic [CW-1:0]   b_tx_pkt_count, b_rx_pkt_count, b_rx_err_count;
    logic [TDW-1:0]  b_tx_tdata, b_rx_tdata;

    axis_traffic_gen #(.TDATA_WIDTH(TDW), .TDEST_WIDTH(TDST), .NUM_DESTS(ND),
                       .SRC_ID(3), .CNT_WIDTH(CW)) dut_rx (
        .clk_usr(clk), .rst_n(rst_n), .start(b_start), .abort(1'b0), .mode(2'd0),
        .fixed_dest('0), .pkt_len(8'd2), .num_pkts('0),
        .tx_tvalid(b_tx_tvalid), .tx_tready(1'b1), .tx_tdata(b_tx_tdata),
        .tx_tlast(b_tx_tlast), .tx_tdest(b_tx_tdest),
        .rx_tvalid(b_rx_tvalid), .rx_tready(b_rx_tready), .rx_tdata(b_rx_tdata),
        .rx_tlast(b_rx_tlast), .rx_tdest(b_rx_tdest), .busy(b_busy), .done(b_done),
        .tx_pkt_count(b_tx_pkt_count), .rx_pkt_count(b_rx_pkt_count),
        .rx_err_count(b_rx_err_count), .state_dbg(b_state_dbg)
    );

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model of one run: packet p goes to its mode's destination and
    // carries {src, p mod 256, beat} on each beat.
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {v[14:0], ^(v & 16'hB400)};
    endfunction

    task automatic push_run(input int m, input int fd, input int len, input int n, input int max_pkts);
        logic [15:0]    lf;
        int             eff_len, eff_mode, pkts;
        logic [TDST-1:0] d;
        logic [TDW-1:0] data;
        lf       = 16'hACE1;
        eff_len  = (len == 0) ? 1 : len;
        eff_mode = (m == 3) ? 0 : m;
        pkts     = (n < max_pkts) ? n : max_pkts;
        for (int p = 0; p < pkts; p++) begin
            if (eff_mode == 1)      d = TDST'(p % ND);
            else if (eff_mode == 2) d = TDST'(lf % ND);
            else                    d = TDST'(fd);
            for (int b = 0; b < eff_len; b++) begin
                data = '0;
                data[TDW-1 -: 8] = 8'd2;
                data[15:8] = 8'(p % 256);
                data[7:0]  = 8'(b);
                exp_q.push_back({d, (b == eff_len - 1), data});
            end
            lf = lfsr_step(lf);
        end
    endtask

    // Monitor: every accepted tx beat is matched against the queue head; a
    // stalled beat must be presented unchanged in the next cycle.
    logic [W-1:0] prev_word;
    logic         prev_stall = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && prev_stall && tx_tvalid === 1'b1) begin
                check("tx_hold", 64'({tx_tdest, tx_tlast, tx_tdata}), 64'(prev_word));
            end
            if (rst_n === 1'b1 && tx_tvalid === 1'b1 && tx_tready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL tx_unexpected: got beat 0x%0h, expected no beat at %0t",
                             {tx_tdest, tx_tlast, tx_tdata}, $time);
                end else begin
                    check("tx_beat", 64'({tx_tdest, tx_tlast, tx_tdata}), 64'(exp_q.pop_front()));
                end
            end
            prev_stall = (rst_n === 1'b1) && (tx_tvalid === 1'b1) && (tx_tready !== 1'b1);
            prev_word  = {tx_tdest, tx_tlast, tx_tdata};
        end
    end

    // ---------------- driver tasks ----------------
    int       ready_mode = 0;  // 0 always ready, 1 random, 2 pattern 1,0,0,1
    int       pat_idx = 0;
    logic [3:0] ready_pat = 4'b1001;

    initial begin
        tx_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                1:       tx_tready = 1'($urandom_range(0, 1));
                2:       begin tx_tready = ready_pat[3 - (pat_idx % 4)]; pat_idx++; end
                default: tx_tready = 1'b1;
            endcase
        end
    end

    int m_idx = 0, m_pkt = 0, m_err = 0;

    task automatic apply_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; b_start = 1'b0; b_rx_tvalid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst_tvalid", 64'(tx_tvalid), 64'd0);
        check("rst_state", 64'(state_dbg), 64'd0);
        check("rst_busy_done", 64'({busy, done}), 64'd0);
        check("rst_tx_cnt", 64'(tx_pkt_count), 64'd0);
        check("rst_rx_cnts", 64'({b_rx_pkt_count, b_rx_err_count}), 64'd0);
        check("rst_rx_tready", 64'(rx_tready), 64'd0);
        exp_q.delete();
        m_idx = 0; m_pkt = 0; m_err = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("post_rst_rx_tready", 64'(rx_tready), 64'd1);
    endtask

    task automatic start_run(input int m, input int fd, input int len, input int n);
        @(posedge clk);
        #1;
        mode = 2'(m); fixed_dest = TDST'(fd); pkt_len = 8'(len); num_pkts = CW'(n);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int c = 0;
        while (done !== 1'b1 && c < budget) begin
            @(negedge clk);
            c++;
        end
        check("run_done", 64'(done), 64'd1);
    endtask

    task automatic wait_beats(input int n, input int budget);
        int got = 0, c = 0;
        while (got < n && c < budget) begin
            @(negedge clk);
            c++;
            if (tx_tvalid === 1'b1 && tx_tready === 1'b1) got++;
        end
        check("beat_count", 64'(got), 64'(n));
    endtask

    task automatic b_kick();
        @(posedge clk);
        #1;
        b_start = 1'b1;
        @(posedge clk);
        #1;
        b_start = 1'b0;
        if (CHK) begin m_pkt = 0; m_err = 0; end
    endtask

    // One rx beat into DUT B; the model applies the receive rules from scratch.
    task automatic rx_beat(input int dest, input int idx, input bit last, input bit with_start);
        bit bad;
        @(posedge clk);
        #1;
        b_rx_tvalid = 1'b1; b_rx_tdest = TDST'(dest); b_rx_tlast = last;
        b_rx_tdata = {8'd9, 16'h0, 8'(idx)};
        b_start = with_start;
        @(posedge clk);
        #1;
        b_rx_tvalid = 1'b0; b_start = 1'b0;
        if (CHK) begin
            bad = (dest != 3) || (idx != m_idx) || (last != (m_idx == 1));
            if (with_start) begin
                m_pkt = 0; m_err = 0;
            end else begin
                if (last) m_pkt++;
                if (bad)  m_err++;
            end
            m_idx = last ? 0 : m_idx + 1;
        end
    endtask

    task automatic check_rx(input string name);
        @(negedge clk);
        check({name, "_pkt"}, 64'(b_rx_pkt_count), 64'(m_pkt));
        check({name, "_err"}, 64'(b_rx_err_count), 64'(m_err));
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    // ---------------- main sequence ----------------
    initial begin
        int m, fd, len, n, bound;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; mode = 2'd0; fixed_dest = '0;
        pkt_len = 8'd1; num_pkts = '0;
        b_start = 1'b0; b_rx_tvalid = 1'b0; b_rx_tdata = '0; b_rx_tlast = 1'b0; b_rx_tdest = '0;
        apply_reset();

        // Fixed dest, 2 packets of 3 beats; done one cycle after the last beat.
        push_run(0, 1, 3, 2, 2);
        start_run(0, 1, 3, 2);
        wait_beats(6, 200);
        @(negedge clk);
        check("s1_done", 64'({done, busy, tx_tvalid}), 64'b100);
        check("s1_tx_cnt", 64'(tx_pkt_count), 64'd2);
        check("s1_missing", 64'(exp_q.size()), 64'd0);

        // Round-robin, 6 single-beat packets; a start mid-run must be ignored.
        push_run(1, 0, 1, 6, 6);
        start_run(1, 0, 1, 6);
        @(posedge clk);
        #1;
        start = 1'b1; num_pkts = CW'(1);
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(200);
        check("s2_tx_cnt", 64'(tx_pkt_count), 64'd6);
        check("s2_missing", 64'(exp_q.size()), 64'd0);

        // Back-pressure pattern on a 4-beat packet.
        ready_mode = 2;
        push_run(0, 5, 4, 1, 1);
        start_run(0, 5, 4, 1);
        wait_done(200);
        ready_mode = 0;
        check("s3_tx_cnt", 64'(tx_pkt_count), 64'd1);
        check("s3_missing", 64'(exp_q.size()), 64'd0);

        // Abort on beat 1 of packet 0: the packet completes, the run stops.
        push_run(0, 3, 4, 10, 1);
        start_run(0, 3, 4, 10);
        bound = 0;
        while (!(tx_tvalid === 1'b1 && tx_tdata[7:0] == 8'd1) && bound < 50) begin
            @(posedge clk);
            #1;
            bound++;
        end
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        wait_done(200);
        check("s4_state", 64'(state_dbg), 64'd2);
        check("s4_tx_cnt", 64'(tx_pkt_count), 64'd1);
        check("s4_missing", 64'(exp_q.size()), 64'd0);

        // LFSR destinations, directed.
        push_run(2, 0, 2, 5, 5);
        start_run(2, 0, 2, 5);
        wait_done(200);
        check("s5_tx_cnt", 64'(tx_pkt_count), 64'd5);
        check("s5_missing", 64'(exp_q.size()), 64'd0);

        // Randomized runs with random back-pressure.
        ready_mode = 1;
        for (int r = 0; r < 8; r++) begin
            m   = $urandom_range(0, 3);
            fd  = $urandom_range(0, 15);
            len = $urandom_range(0, 5);
            n   = $urandom_range(1, 6);
            push_run(m, fd, len, n, n);
            start_run(m, fd, len, n);
            wait_done(3000);
            check("rand_tx_cnt", 64'(tx_pkt_count), 64'(n));
            check("rand_missing", 64'(exp_q.size()), 64'd0);
        end
        ready_mode = 0;

        // Reset mid-packet, then an empty run goes straight to DONE.
        push_run(0, 0, 8, 3, 3);
        start_run(0, 0, 8, 3);
        repeat (3) @(posedge clk);
        apply_reset();
        start_run(0, 0, 2, 0);
        @(negedge clk);
        check("s6_empty_run", 64'({state_dbg, done, busy, tx_tvalid}), 64'b10100);
        repeat (3) @(negedge clk);
        check("s6_no_beats", 64'(tx_pkt_count), 64'd0);

        // Receive checker on DUT B (SRC_ID=3, pkt_len=2).
        b_kick();
        rx_beat(3, 0, 1'b0, 1'b0);
        rx_beat(3, 1, 1'b1, 1'b0);
        check_rx("rx_good");
        rx_beat(2, 0, 1'b0, 1'b0);
        rx_beat(2, 1, 1'b1, 1'b0);
        check_rx("rx_bad_dest");
        for (int k = 0; k < 10; k++) begin
            rx_beat($urandom_range(2, 3), $urandom_range(0, 1), 1'($urandom_range(0, 1)), 1'b0);
        end
        check_rx("rx_rand");
        check("rx_tready_b", 64'(b_rx_tready), 64'd1);
        rx_beat(3, 0, 1'b1, 1'b1);
        check_rx("rx_start_clear");

        repeat (4) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
